// File: rtl/addertree_acc_ctrl_pkg.sv
// Shared types and constants for the accumulation controller.
// Optional feature macro: ACC_SAT_CNT_EN (clip event counter).
package npu_acc_pkg;
  localparam int PRE_W = 13;
  localparam int SUM_W = 20;
  localparam int LANES = 9;
  localparam logic signed [PRE_W-1:0] CLIP_MAX = 13'sd4095;
  localparam logic signed [PRE_W-1:0] CLIP_MIN = -13'sd4096;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    OUT
  } state_t;
endpackage

// File: rtl/addertree_acc_ctrl_if.sv
// Operand, datapath and result bundle of the accumulation controller.
// master = controller side, slave = source/datapath/sink side.
interface addertree_acc_ctrl_if;
  import npu_acc_pkg::*;

  logic                      in_valid;
  logic                      in_ready;
  logic [LANES*8-1:0]        in_mcand;
  logic [LANES*8-1:0]        in_mplier;
  logic signed [15:0]        in_bias;

  logic                      dp_valid;
  logic [LANES*8-1:0]        dp_mcand;
  logic [LANES*8-1:0]        dp_mplier;
  logic signed [15:0]        dp_bias;
  logic signed [PRE_W-1:0]   dp_pre;
  logic signed [SUM_W-1:0]   dp_sum;

  logic                      out_valid;
  logic                      out_ready;
  logic signed [PRE_W-1:0]   out_data;

  modport master (
    input  in_valid, in_mcand, in_mplier, in_bias,
    input  dp_sum, out_ready,
    output in_ready, dp_valid, dp_mcand, dp_mplier,
    output dp_bias, dp_pre, out_valid, out_data
  );

  modport slave (
    output in_valid, in_mcand, in_mplier, in_bias,
    output dp_sum, out_ready,
    input  in_ready, dp_valid, dp_mcand, dp_mplier,
    input  dp_bias, dp_pre, out_valid, out_data
  );
endinterface

// File: rtl/addertree_acc_ctrl_clip.sv
// Saturating 20->13 bit clipper for the datapath sum.
// Rails are detected from the top two sum bits; otherwise sum[18:6].
module acc_clip
  import npu_acc_pkg::*;
(
  input  logic signed [SUM_W-1:0] sum,
  output logic signed [PRE_W-1:0] clip,
  output logic                    sat
);

  logic unused_lsb;
  assign unused_lsb = ^sum[5:0];

  // Pick positive rail, negative rail or scaled pass-through.
  always_comb begin
    clip = sum[18:6];
    sat  = 1'b0;
    unique case (1'b1)
      (sum[19:18] == 2'b01): begin
        clip = CLIP_MAX;
        sat  = 1'b1;
      end
      (sum[19:18] == 2'b10): begin
        clip = CLIP_MIN;
        sat  = 1'b1;
      end
      default: begin
        clip = sum[18:6];
        sat  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/addertree_acc_ctrl.sv
// Pass sequencer and feedback accumulator around the adder-tree datapath.
// Optional macro ACC_SAT_CNT_EN adds the sat_cnt clip event counter.
module addertree_acc_ctrl
  import npu_acc_pkg::*;
#(
  parameter int NUM_PASS = 4,
  parameter int PIPE_LAT = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  addertree_acc_ctrl_if.master   bus,
  output logic [3:0]             pass_idx,
  output logic                   busy
`ifdef ACC_SAT_CNT_EN
  ,
  output logic [15:0]            sat_cnt
`endif
);

  localparam int CW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

  state_t                  state;
  logic [CW-1:0]           cnt;
  logic signed [PRE_W-1:0] clip;
  logic                    clip_sat;
  logic                    cap;
  logic                    last;

  acc_clip u_clip (
    .sum  (bus.dp_sum),
    .clip (clip),
    .sat  (clip_sat)
  );

  assign busy = (state != IDLE);
  assign last = (pass_idx == 4'(NUM_PASS - 1));

  // The sum is taken at the end of ISSUE or when the wait expires.
  always_comb begin
    cap = 1'b0;
    if (state == ISSUE && PIPE_LAT == 0)
      cap = 1'b1;
    if (state == WAIT && cnt == CW'(PIPE_LAT - 1))
      cap = 1'b1;
  end

  // Controller FSM with registered handshake and datapath outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      pass_idx      <= '0;
      bus.in_ready  <= 1'b1;
      bus.dp_valid  <= 1'b0;
      bus.dp_mcand  <= '0;
      bus.dp_mplier <= '0;
      bus.dp_bias   <= '0;
      bus.dp_pre    <= '0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
    end else begin
      bus.dp_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.in_valid) begin
            bus.dp_mcand  <= bus.in_mcand;
            bus.dp_mplier <= bus.in_mplier;
            bus.dp_bias   <= (pass_idx == '0) ?
                             bus.in_bias : '0;
            bus.dp_valid  <= 1'b1;
            bus.in_ready  <= 1'b0;
            state         <= ISSUE;
          end
        end
        ISSUE: begin
          if (PIPE_LAT != 0) begin
            cnt   <= '0;
            state <= WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt + 1'b1;
        end
        OUT: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            bus.in_ready  <= 1'b1;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
      if (cap) begin
        if (last) begin
          bus.out_data  <= clip;
          bus.out_valid <= 1'b1;
          bus.dp_pre    <= '0;
          pass_idx      <= '0;
          state         <= OUT;
        end else begin
          bus.dp_pre    <= clip;
          bus.in_ready  <= 1'b1;
          pass_idx      <= pass_idx + 1'b1;
          state         <= IDLE;
        end
      end
    end
  end

`ifdef ACC_SAT_CNT_EN
  // Count clipping captures, sticking at all-ones.
  always_ff @(posedge clk) begin
    if (reset)
      sat_cnt <= '0;
    else if (cap && clip_sat && sat_cnt != 16'hFFFF)
      sat_cnt <= sat_cnt + 1'b1;
  end
`else
  logic unused_sat;
  assign unused_sat = clip_sat;
`endif

endmodule
